// File: rtl/ifft_pkg.sv
// Shared types and constants for the sound-path inverse FFT engine.
// Holds the default geometry, the complex sample type, the FSM encoding and the bit-reverse helper.
package ifft_pkg;

  localparam int N     = 16;
  localparam int LOG2N = 4;
  localparam int DW    = 16;

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } cplx_t;

  typedef enum logic [1:0] {IDLE, BFLY, FINISH} state_t;

  // Reverse the low 'bits' bits of i.
  function automatic int bitrev(input int i, input int bits);
    int r;
    r = 0;
    for (int j = 0; j < bits; j++)
      r[j] = i[bits-1-j];
    return r;
  endfunction

endpackage

// File: rtl/ifft_sound_loop_butterfly.sv
// Inverse radix-2 butterfly: multiplies by the conjugated forward twiddle,
// then halves the sum/difference with round-half-up and saturates to DW bits.
module ifft_sound_loop_butterfly
  import ifft_pkg::*;
#(
  parameter int DW = ifft_pkg::DW
) (
  input  logic signed [DW-1:0] ar,
  input  logic signed [DW-1:0] ai,
  input  logic signed [DW-1:0] br,
  input  logic signed [DW-1:0] bi,
  input  logic signed [DW-1:0] wr,
  input  logic signed [DW-1:0] wi,
  output logic signed [DW-1:0] top_re,
  output logic signed [DW-1:0] top_im,
  output logic signed [DW-1:0] bot_re,
  output logic signed [DW-1:0] bot_im
);

  localparam int PW = 2*DW + 1;
  localparam int TW = DW + 2;
  localparam int UW = DW + 3;

  logic signed [2*DW-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [PW-1:0]   s_re, s_im;
  logic signed [TW-1:0]   t_re, t_im;
  logic signed [UW-1:0]   u_tr, u_ti, u_br, u_bi;

  function automatic logic signed [DW-1:0] sat(input logic signed [UW-1:0] u);
    logic signed [TW-1:0] v;
    v = u[UW-1:1];
    if (v[TW-1:DW-1] == '0 || v[TW-1:DW-1] == '1)
      return v[DW-1:0];
    else
      return v[TW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
  endfunction

  always_comb begin
    p_rr = (2*DW)'(wr) * (2*DW)'(br);
    p_ii = (2*DW)'(wi) * (2*DW)'(bi);
    p_ri = (2*DW)'(wr) * (2*DW)'(bi);
    p_ir = (2*DW)'(wi) * (2*DW)'(br);
    // conj(W) * b: real = wr*br + wi*bi, imag = wr*bi - wi*br
    s_re = PW'(p_rr) + PW'(p_ii) + PW'(1 << (DW-2));
    s_im = PW'(p_ri) - PW'(p_ir) + PW'(1 << (DW-2));
    t_re = s_re[PW-1:DW-1];
    t_im = s_im[PW-1:DW-1];
    u_tr = UW'(ar) + UW'(t_re) + UW'(1);
    u_ti = UW'(ai) + UW'(t_im) + UW'(1);
    u_br = UW'(ar) - UW'(t_re) + UW'(1);
    u_bi = UW'(ai) - UW'(t_im) + UW'(1);
    top_re = sat(u_tr);
    top_im = sat(u_ti);
    bot_re = sat(u_br);
    bot_im = sat(u_bi);
  end

endmodule

// File: rtl/ifft_sound_loop.sv
// Iterative radix-2 inverse FFT: one butterfly per clock over an in-place register file,
// result scaled by 1/N through per-stage halving, start/done handshake to the host.
module ifft_sound_loop
  import ifft_pkg::*;
#(
  parameter int N     = ifft_pkg::N,
  parameter int LOG2N = ifft_pkg::LOG2N,
  parameter int DW    = ifft_pkg::DW
) (
  input  logic                   Clock,
  input  logic                   Areset,
  input  logic                   Start,
  input  logic [N-1:0][DW-1:0]   BinsReal,
  input  logic [N-1:0][DW-1:0]   BinsImag,
  input  logic [N/2-1:0][DW-1:0] WReal,
  input  logic [N/2-1:0][DW-1:0] WImag,
  output logic [N-1:0][DW-1:0]   SamplesReal,
  output logic [N-1:0][DW-1:0]   SamplesImag,
  output logic                   Busy,
  output logic                   Done
);

  localparam int BW = LOG2N - 1;
  localparam int SW = $clog2(LOG2N);
  localparam logic [BW-1:0] B_LAST = '1;
  localparam logic [SW-1:0] S_LAST = SW'(LOG2N-1);

  state_t state, state_nxt;
  logic   load, step, last;

  logic [BW-1:0]    b;
  logic [SW-1:0]    s;
  logic [LOG2N-1:0] bx, hmask, top_i, bot_i;
  logic [BW-1:0]    k;

  logic [N-1:0][DW-1:0] work_re, work_im, work_re_nxt, work_im_nxt;
  logic [N-1:0][DW-1:0] rev_re, rev_im, smp_re, smp_im;
  logic signed [DW-1:0] yt_re, yt_im, yb_re, yb_im;

  for (genvar g = 0; g < N; g++) begin : g_rev
    assign rev_re[bitrev(g, LOG2N)] = BinsReal[g];
    assign rev_im[bitrev(g, LOG2N)] = BinsImag[g];
  end

  // Pair and twiddle addressing for butterfly b of stage s (h = 2^s).
  always_comb begin
    bx    = {1'b0, b};
    hmask = LOG2N'((1 << s) - 1);
    top_i = ((bx >> s) << (int'(s) + 1)) | (bx & hmask);
    bot_i = top_i | LOG2N'(1 << s);
    k     = BW'((bx & hmask) << (LOG2N - 1 - int'(s)));
    last  = (b == B_LAST) && (s == S_LAST);
  end

  ifft_sound_loop_butterfly #(.DW(DW)) u_bfly (
    .ar     (work_re[top_i]),
    .ai     (work_im[top_i]),
    .br     (work_re[bot_i]),
    .bi     (work_im[bot_i]),
    .wr     (WReal[k]),
    .wi     (WImag[k]),
    .top_re (yt_re),
    .top_im (yt_im),
    .bot_re (yb_re),
    .bot_im (yb_im)
  );

  always_comb begin
    work_re_nxt        = work_re;
    work_im_nxt        = work_im;
    work_re_nxt[top_i] = yt_re;
    work_im_nxt[top_i] = yt_im;
    work_re_nxt[bot_i] = yb_re;
    work_im_nxt[bot_i] = yb_im;
  end

  always_ff @(posedge Clock or negedge Areset) begin
    if (!Areset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    unique case (state)
      IDLE:    if (Start) begin load = 1'b1; state_nxt = BFLY; end
      BFLY:    begin step = 1'b1; if (last) state_nxt = FINISH; end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Samples are captured on the final butterfly edge so they are valid alongside Done.
  always_ff @(posedge Clock or negedge Areset) begin
    if (!Areset) begin
      work_re <= '0;
      work_im <= '0;
      smp_re  <= '0;
      smp_im  <= '0;
      b       <= '0;
      s       <= '0;
    end else if (load) begin
      work_re <= rev_re;
      work_im <= rev_im;
      b       <= '0;
      s       <= '0;
    end else if (step) begin
      work_re <= work_re_nxt;
      work_im <= work_im_nxt;
      b       <= b + BW'(1);
      if (last) begin
        s      <= '0;
        smp_re <= work_re_nxt;
        smp_im <= work_im_nxt;
      end else if (b == B_LAST) begin
        s <= s + SW'(1);
      end
    end
  end

  assign SamplesReal = smp_re;
  assign SamplesImag = smp_im;
  assign Busy        = (state == BFLY);
  assign Done        = (state == FINISH);

endmodule

// File: tb/tb_ifft_sound_loop.sv
// Directed and randomized checks of the inverse FFT engine at N=16, DW=16.
module tb_ifft_sound_loop;
  import ifft_pkg::*;

  logic Clock = 1'b0;
  logic Areset = 1'b0;
  logic Start = 1'b0;
  logic [N-1:0][DW-1:0]   BinsReal, BinsImag, SamplesReal, SamplesImag;
  logic [N/2-1:0][DW-1:0] WReal, WImag;
  logic Busy, Done;

  int n_checks = 0;
  int n_fail   = 0;

  int w_re[8]   = '{32767, 30273, 23170, 12539, 0, -12539, -23170, -30273};
  int w_im[8]   = '{0, -12539, -23170, -30273, -32767, -30273, -23170, -12539};
  int cos16[16] = '{2048, 1892, 1448, 784, 0, -784, -1448, -1892,
                    -2048, -1892, -1448, -784, 0, 784, 1448, 1892};

  always #5 Clock = ~Clock;

  ifft_sound_loop dut (
    .Clock(Clock), .Areset(Areset), .Start(Start),
    .BinsReal(BinsReal), .BinsImag(BinsImag), .WReal(WReal), .WImag(WImag),
    .SamplesReal(SamplesReal), .SamplesImag(SamplesImag), .Busy(Busy), .Done(Done)
  );

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic int rev4(input int i);
    return int'({i[0], i[1], i[2], i[3]});
  endfunction

  function automatic longint sat16(input longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Textbook decimation-in-time inverse FFT in the block's fixed-point format.
  task automatic ref_ifft(input int bre[16], input int bim[16], output cplx_t res[16]);
    longint xr[16], xi[16];
    longint tr, ti, ar, ai;
    int tp, bt, k;
    for (int i = 0; i < 16; i++) begin
      xr[rev4(i)] = bre[i];
      xi[rev4(i)] = bim[i];
    end
    for (int h = 1; h < 16; h = h * 2)
      for (int g = 0; g < 16; g = g + 2*h)
        for (int j = 0; j < h; j++) begin
          tp = g + j; bt = tp + h; k = j * (8 / h);
          tr = (longint'(w_re[k]) * xr[bt] + longint'(w_im[k]) * xi[bt] + 16384) >>> 15;
          ti = (longint'(w_re[k]) * xi[bt] - longint'(w_im[k]) * xr[bt] + 16384) >>> 15;
          ar = xr[tp]; ai = xi[tp];
          xr[tp] = sat16((ar + tr + 1) >>> 1);
          xi[tp] = sat16((ai + ti + 1) >>> 1);
          xr[bt] = sat16((ar - tr + 1) >>> 1);
          xi[bt] = sat16((ai - ti + 1) >>> 1);
        end
    for (int i = 0; i < 16; i++) begin
      res[i].re = 16'(xr[i]);
      res[i].im = 16'(xi[i]);
    end
  endtask

  task automatic set_bins(input int bre[16], input int bim[16]);
    for (int i = 0; i < 16; i++) begin
      BinsReal[i] = 16'(bre[i]);
      BinsImag[i] = 16'(bim[i]);
    end
  endtask

  task automatic set_impulse(input int idx);
    int bre[16], bim[16];
    for (int i = 0; i < 16; i++) begin bre[i] = 0; bim[i] = 0; end
    bre[idx] = 32767;
    set_bins(bre, bim);
  endtask

  // Launch one transform and return the edge count (accept edge = 1) until Done is seen.
  task automatic run_block(output int lat);
    @(negedge Clock); Start = 1'b1;
    @(posedge Clock); #1; Start = 1'b0; lat = 1;
    while (!Done && lat < 200) begin @(posedge Clock); #1; lat++; end
    @(posedge Clock); #1;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (Busy !== 1'b0 || Done !== 1'b0 || SamplesReal !== '0 || SamplesImag !== '0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b re=%h im=%h, required all 0", Busy, Done, SamplesReal, SamplesImag);
    end
    @(negedge Clock); Areset = 1'b1;
  endtask

  task automatic test_impulse();
    int lat, bad;
    set_impulse(0);
    run_block(lat);
    n_checks++;
    if (lat !== 33) begin n_fail++; $display("FAIL impulse_latency: got %0d cycles, required 33", lat); end
    bad = 0;
    for (int i = 0; i < 16; i++)
      if (SamplesReal[i] !== 16'h0800 || SamplesImag[i] !== 16'h0000) bad++;
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL impulse_value: %0d bad samples, re=%h, required all 0800/0000", bad, SamplesReal); end
    n_checks++;
    if (Busy !== 1'b0 || Done !== 1'b0) begin n_fail++; $display("FAIL impulse_idle: busy=%b done=%b, required 0 0", Busy, Done); end
  endtask

  task automatic test_tone();
    int lat, bad;
    set_impulse(1);
    run_block(lat);
    bad = 0;
    for (int i = 0; i < 16; i++)
      if (absd(int'($signed(SamplesReal[i])), cos16[i]) > 2 ||
          absd(int'($signed(SamplesImag[i])), cos16[(i + 12) % 16]) > 2) bad++;
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL tone_bin1: %0d samples off, re=%h im=%h, required 2048*cos/+2048*sin +-2", bad, SamplesReal, SamplesImag); end
    n_checks++;
    if ($signed(SamplesImag[4]) < 16'sd2040) begin n_fail++; $display("FAIL tone_sign: imag[4]=%0d, required about +2048", $signed(SamplesImag[4])); end
  endtask

  task automatic test_flat();
    int lat, bad, bre[16], bim[16];
    for (int i = 0; i < 16; i++) begin bre[i] = 32767; bim[i] = 0; end
    set_bins(bre, bim);
    run_block(lat);
    n_checks++;
    if (absd(int'($signed(SamplesReal[0])), 32767) > 2) begin n_fail++; $display("FAIL flat_dc: re[0]=%0d, required 32767 +-2", $signed(SamplesReal[0])); end
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (i != 0 && absd(int'($signed(SamplesReal[i])), 0) > 2) bad++;
      if (absd(int'($signed(SamplesImag[i])), 0) > 2) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL flat_rest: %0d components off, re=%h im=%h, required 0 +-2", bad, SamplesReal, SamplesImag); end
  endtask

  task automatic test_restart_ignored();
    int ndone, bad;
    set_impulse(0);
    ndone = 0;
    @(negedge Clock); Start = 1'b1;
    @(posedge Clock); #1;
    for (int c = 2; c <= 60; c++) begin
      @(negedge Clock); Start = (c == 10);
      @(posedge Clock); #1;
      if (Done) ndone++;
    end
    Start = 1'b0;
    n_checks++;
    if (ndone != 1) begin n_fail++; $display("FAIL restart_done_count: got %0d pulses, required 1", ndone); end
    bad = 0;
    for (int i = 0; i < 16; i++)
      if (SamplesReal[i] !== 16'h0800 || SamplesImag[i] !== 16'h0000) bad++;
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL restart_value: %0d bad samples, required all 0800/0000", bad); end
  endtask

  task automatic test_abort();
    int ndone, lat, bad;
    set_impulse(1);
    @(negedge Clock); Start = 1'b1;
    @(posedge Clock); #1; Start = 1'b0;
    repeat (14) @(posedge Clock);
    #2 Areset = 1'b0;
    #1;
    n_checks++;
    if (Busy !== 1'b0 || Done !== 1'b0 || SamplesReal !== '0 || SamplesImag !== '0) begin
      n_fail++;
      $display("FAIL abort_clear: busy=%b done=%b re=%h im=%h, required all 0", Busy, Done, SamplesReal, SamplesImag);
    end
    @(negedge Clock); Areset = 1'b1;
    ndone = 0;
    repeat (40) begin @(posedge Clock); #1; if (Done) ndone++; end
    n_checks++;
    if (ndone != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses, required 0", ndone); end
    set_impulse(0);
    run_block(lat);
    bad = 0;
    for (int i = 0; i < 16; i++)
      if (SamplesReal[i] !== 16'h0800 || SamplesImag[i] !== 16'h0000) bad++;
    n_checks++;
    if (lat !== 33 || bad != 0) begin n_fail++; $display("FAIL abort_recover: latency %0d bad %0d, required 33 and 0", lat, bad); end
  endtask

  task automatic test_back_to_back();
    int d1, d2;
    set_impulse(0);
    d1 = 0; d2 = 0;
    @(negedge Clock); Start = 1'b1;
    for (int c = 1; c <= 120 && d2 == 0; c++) begin
      @(posedge Clock); #1;
      if (Done) begin if (d1 == 0) d1 = c; else d2 = c; end
    end
    @(negedge Clock); Start = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    n_checks++;
    if (d1 != 33 || d2 - d1 != 34) begin n_fail++; $display("FAIL back_to_back: done at %0d and %0d, required 33 and 67", d1, d2); end
    n_checks++;
    if (SamplesReal[7] !== 16'h0800 || Busy !== 1'b0) begin n_fail++; $display("FAIL back_to_back_value: re[7]=%h busy=%b, required 0800 0", SamplesReal[7], Busy); end
  endtask

  task automatic test_random();
    int lat, bad, bre[16], bim[16];
    cplx_t exp_s[16];
    for (int blk = 0; blk < 1000; blk++) begin
      for (int i = 0; i < 16; i++) begin
        bre[i] = int'($signed(16'($urandom())));
        bim[i] = int'($signed(16'($urandom())));
      end
      set_bins(bre, bim);
      ref_ifft(bre, bim, exp_s);
      run_block(lat);
      bad = 0;
      for (int i = 0; i < 16; i++)
        if (SamplesReal[i] !== exp_s[i].re || SamplesImag[i] !== exp_s[i].im) bad++;
      n_checks++;
      if (bad != 0 || lat != 33) begin
        n_fail++;
        $display("FAIL random_blk%0d: %0d bad samples, latency %0d, re[0]=%h required %h", blk, bad, lat, SamplesReal[0], exp_s[0].re);
      end
    end
  endtask

  initial begin
    BinsReal = '0;
    BinsImag = '0;
    for (int i = 0; i < 8; i++) begin
      WReal[i] = 16'(w_re[i]);
      WImag[i] = 16'(w_im[i]);
    end
    repeat (2) @(posedge Clock);
    test_reset();
    test_impulse();
    test_tone();
    test_flat();
    test_restart_ignored();
    test_abort();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
